// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes RV32I OP/OP-IMM, reads the register file and registers ALU select and operands
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_g_sel,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        illegal
);
  logic [31:0] regs_q [32];
  logic        valid_q, illegal_q;
  logic [3:0]  g_sel_q, g_sel_d;
  logic [31:0] a_q, b_q, b_d, rs1_v, rs2_v;
  logic [4:0]  rd_q, rs1, rs2;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        is_op, is_imm, op_ok, imm_ok, legal, accept, shift_imm;
  assign opcode    = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign is_op     = opcode == 7'b0110011;
  assign is_imm    = opcode == 7'b0010011;
  assign shift_imm = f3 == 3'b001 || f3 == 3'b101;
  assign op_ok     = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign imm_ok    = f3 == 3'b001 ? f7 == 7'b0 :
                     f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
  assign legal     = (is_op && op_ok) || (is_imm && imm_ok);
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // write-through lets an operand see a writeback landing in the accept cycle
  assign rs1_v = rs1 == 5'd0 ? 32'd0 : (wb_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
  assign rs2_v = rs2 == 5'd0 ? 32'd0 : (wb_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
  always_comb begin
    g_sel_d = is_op ? {f3, f7[5]} : {f3, f3 == 3'b101 && in_instr[30]};
    b_d     = is_op ? rs2_v : shift_imm ? {27'd0, rs2} : {{20{in_instr[31]}}, in_instr[31:20]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      g_sel_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        valid_q <= 1'b1;
        g_sel_q <= g_sel_d;
        a_q     <= rs1_v;
        b_q     <= b_d;
        rd_q    <= in_instr[11:7];
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (wb_en && wb_rd != 5'd0) regs_q[wb_rd] <= wb_data;
    end
  end
  assign out_valid = valid_q;
  assign out_g_sel = g_sel_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with hand-computed expectations for alu_operand_stage
module tb_alu_operand_stage;
  logic        clk = 0, rst, in_valid, in_ready, wb_en, out_valid, out_ready, illegal;
  logic [31:0] in_instr, wb_data, out_a, out_b;
  logic [4:0]  wb_rd, out_rd;
  logic [3:0]  out_g_sel;
  int checks = 0, errors = 0;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_g_sel(out_g_sel), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [3:0] g, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".gsel"}, 32'(out_g_sel), 32'(g));
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".rd"}, 32'(out_rd), 32'(rd));
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid = 1;
    in_instr = instr;
    step();
    in_valid = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
    step(); step();
    rst = 0;
    #1;
    check("rst.valid", 32'(out_valid), 0);
    check("rst.gsel", 32'(out_g_sel), 0);
    check("rst.a", out_a, 0);
    check("rst.b", out_b, 0);
    check("rst.rd", 32'(out_rd), 0);
    check("rst.illegal", 32'(illegal), 0);
    check("rst.in_ready", 32'(in_ready), 1);

    out_ready = 1;
    issue(32'h00500093);
    slot("addi", 4'b0000, 0, 5, 1);

    wb_en = 1; wb_rd = 1; wb_data = 7;
    step();
    check("release.valid", 32'(out_valid), 0);
    wb_rd = 2; wb_data = 3;
    issue(32'h402081B3);
    wb_en = 0;
    slot("sub_wt", 4'b0001, 7, 3, 3);

    in_valid = 1; in_instr = 32'h4030D213;
    step();
    slot("srai", 4'b1011, 7, 3, 4);
    in_instr = 32'hFFF00293;
    step();
    in_valid = 0;
    slot("addi_neg", 4'b0000, 0, 32'hFFFFFFFF, 5);

    issue(32'h00208333);
    out_ready = 0;
    in_valid = 1; in_instr = 32'h0020C3B3;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall.in_ready", 32'(in_ready), 0);
      slot("stall", 4'b0000, 7, 3, 6);
      step();
    end
    out_ready = 1;
    #1;
    check("unstall.in_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    slot("xor", 4'b1000, 7, 3, 7);

    issue(32'h00000003);
    check("ill_load.pulse", 32'(illegal), 1);
    check("ill_load.valid", 32'(out_valid), 0);
    step();
    check("ill_load.clear", 32'(illegal), 0);
    issue(32'h4020F1B3);
    check("ill_op.pulse", 32'(illegal), 1);
    check("ill_op.valid", 32'(out_valid), 0);
    step();
    check("ill_op.clear", 32'(illegal), 0);
    issue(32'h40109093);
    check("ill_slli.pulse", 32'(illegal), 1);
    check("ill_slli.valid", 32'(out_valid), 0);
    step();
    check("ill_slli.clear", 32'(illegal), 0);

    wb_en = 1; wb_rd = 0; wb_data = 32'hDEAD;
    step();
    issue(32'h00000333);
    wb_en = 0;
    slot("x0", 4'b0000, 0, 0, 6);

    out_ready = 0;
    rst = 1; wb_en = 1; wb_rd = 1; wb_data = 32'h55;
    step();
    rst = 0; wb_en = 0;
    check("midrst.valid", 32'(out_valid), 0);
    check("midrst.illegal", 32'(illegal), 0);
    out_ready = 1;
    issue(32'h00208433);
    slot("after_rst", 4'b0000, 0, 0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
